// File: rtl/tx_framer_pkg.sv
// Shared types and helpers for the sample-to-UART frame packetizer.
// Frames are: sync byte, sample bytes MSB first, XOR of the sample bytes.
package tx_framer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitAck,
    StWaitDone
  } state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // Widest sample the checksum helper accepts.
  localparam int unsigned MaxDataW = 64;

  function automatic logic [7:0] xor_bytes(input logic [MaxDataW-1:0] data,
                                           input int unsigned        nbytes);
    logic [7:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < MaxDataW / 8; i++) begin
      if (i < nbytes) acc ^= data[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/tx_framer.sv
// Wraps each averaged sample into a sync/data/checksum frame and feeds it to the UART
// one byte at a time, with a one-deep shadow buffer for samples arriving mid-frame.
module tx_framer
  import tx_framer_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              frame_busy,
  output logic              overrun
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IdxW   = $clog2(NBYTES + 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        chk;
  logic [7:0]        byte_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      frame_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      overrun_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      overrun_q    <= overrun_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (sample_valid) begin
          // A fresh sample beats the pending one; the pending one is lost.
          frame_d = sample;
          idx_d   = '0;
          state_d = StStart;
          if (pend_valid_q) begin
            pend_valid_d = 1'b0;
            overrun_d    = 1'b1;
          end
        end else if (pend_valid_q) begin
          frame_d      = pend_q;
          pend_valid_d = 1'b0;
          idx_d        = '0;
          state_d      = StStart;
        end
      end
      StStart: begin
        if (!tx_busy) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (sample_valid && state_q != StIdle) begin
      pend_d       = sample;
      pend_valid_d = 1'b1;
      if (pend_valid_q) overrun_d = 1'b1;
    end
  end

  assign chk = xor_bytes(MaxDataW'(frame_q), NBYTES);

  always_comb begin
    byte_sel = SYNC_BYTE;
    if (idx_q == LastIdx) begin
      byte_sel = chk;
    end else begin
      for (int unsigned k = 1; k <= NBYTES; k++) begin
        if (idx_q == IdxW'(k)) byte_sel = frame_q[DATA_W - 8*k +: 8];
      end
    end
  end

  // tx_data is latched with the launch so it holds for the whole UART byte.
  always_comb begin
    tx_start_d = (state_q == StStart) && !tx_busy;
    tx_data_d  = tx_start_d ? byte_sel : tx_data_q;
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_busy = (state_q != StIdle);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: expected frame bytes are queued as samples are issued and
// popped by a monitor on each tx_start; a simple UART model answers the handshake.
module tb_tx_framer;

  localparam int NB = 3;

  typedef struct {
    logic [7:0] b;
    bit         gap_chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample = '0;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        overrun;

  tx_framer dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .frame_busy  (frame_busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   start_cnt = 0;
  int   cyc = 0;
  int   last_fall = 0;
  logic prev_busy = 1'b0;
  logic exp_ovr = 1'b0;

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  int   busy_len = 10;
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start) busy_cnt <= busy_len;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Monitor: every tx_start must carry the next expected byte.
  always @(negedge clk) begin
    if (prev_busy && !tx_busy) last_fall = cyc;
    prev_busy = tx_busy;
    if (reset && tx_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(e.b));
        if (e.gap_chk) check("start_gap_le3", 32'(cyc - last_fall <= 3), 32'd1);
      end
    end
  end

  // Reference frame built straight from the framing rule.
  task automatic push_frame(input logic [23:0] d, input bit chained);
    logic [7:0] chk;
    exp_t       e;
    chk = 8'h00;
    e.b = 8'hA5;
    e.gap_chk = chained;
    exp_q.push_back(e);
    for (int k = NB - 1; k >= 0; k--) begin
      e.b = 8'((d >> (8 * k)) & 24'hFF);
      e.gap_chk = 1'b1;
      chk = chk ^ e.b;
      exp_q.push_back(e);
    end
    e.b = chk;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; returns one cycle later.
  task automatic pulse(input logic [23:0] d);
    sample = d;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int target);
    int guard = 0;
    while (start_cnt < target && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) fail_timeout("wait_starts");
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      fail_timeout("frame_drain");
      exp_q.delete();
    end
    wait_cycles(1);
    guard = 0;
    while (tx_busy && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) fail_timeout("final_busy_fall");
    check("frame_busy_at_last_fall", 32'(frame_busy), 32'd1);
    wait_cycles(1);
    check("frame_busy_after_frame", 32'(frame_busy), 32'd0);
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          base;
    int          mode;
    int          k;
    logic [23:0] d;
    logic [23:0] d2;

    wait_cycles(3);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_frame_busy", 32'(frame_busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    wait_cycles(2);

    // Single frame with first-byte latency check.
    busy_len = 10;
    base = start_cnt;
    push_frame(24'h123456, 1'b0);
    pulse(24'h123456);
    check("lat_n1_tx_start", 32'(tx_start), 32'd0);
    wait_cycles(1);
    check("lat_n2_tx_start", 32'(tx_start), 32'd1);
    check("lat_n2_tx_data", 32'(tx_data), 32'hA5);
    wait_done();
    check("single_start_count", 32'(start_cnt - base), 32'd5);

    // Checksum edges.
    push_frame(24'hFFFFFF, 1'b0);
    pulse(24'hFFFFFF);
    wait_done();
    push_frame(24'h000000, 1'b0);
    pulse(24'h000000);
    wait_done();

    // Pending sample arriving during byte 2.
    base = start_cnt;
    push_frame(24'h0000AA, 1'b0);
    pulse(24'h0000AA);
    wait_starts(base + 2);
    push_frame(24'h0000BB, 1'b1);
    pulse(24'h0000BB);
    wait_done();
    check("pending_start_count", 32'(start_cnt - base), 32'd10);

    // UART busy when the sample arrives.
    force_busy = 1'b1;
    base = start_cnt;
    d = 24'($urandom);
    push_frame(d, 1'b0);
    pulse(d);
    wait_cycles(20);
    check("no_start_while_busy", 32'(start_cnt - base), 32'd0);
    force_busy = 1'b0;
    wait_done();

    // Randomized frames: plain, with pending follow-up, or with overrun.
    for (int it = 0; it < 10; it++) begin
      busy_len = $urandom_range(1, 12);
      mode = $urandom_range(0, 2);
      base = start_cnt;
      d = 24'($urandom);
      push_frame(d, 1'b0);
      pulse(d);
      if (mode == 1) begin
        k = $urandom_range(1, 5);
        wait_starts(base + k);
        d2 = 24'($urandom);
        push_frame(d2, 1'b1);
        pulse(d2);
      end else if (mode == 2) begin
        k = $urandom_range(1, 4);
        wait_starts(base + k);
        pulse(24'($urandom));
        wait_cycles($urandom_range(0, 3));
        d2 = 24'($urandom);
        push_frame(d2, 1'b1);
        pulse(d2);
        exp_ovr = 1'b1;
      end
      wait_done();
    end

    // Directed overrun: latest pending value wins.
    busy_len = 10;
    base = start_cnt;
    d = 24'($urandom);
    push_frame(d, 1'b0);
    pulse(d);
    wait_starts(base + 1);
    pulse(24'h000001);
    wait_cycles(3);
    push_frame(24'h000002, 1'b1);
    pulse(24'h000002);
    check("overrun_set", 32'(overrun), 32'd1);
    exp_ovr = 1'b1;
    wait_done();

    // Reset during byte 3 aborts the frame and clears overrun.
    base = start_cnt;
    d = 24'($urandom);
    push_frame(d, 1'b0);
    pulse(d);
    wait_starts(base + 3);
    wait_cycles(2);
    reset = 1'b0;
    #1;
    check("abort_tx_start", 32'(tx_start), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'h00);
    check("abort_frame_busy", 32'(frame_busy), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    exp_ovr = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);
    check("no_resume_after_reset", 32'(frame_busy), 32'd0);
    base = start_cnt;
    push_frame(24'hABCDEF, 1'b0);
    pulse(24'hABCDEF);
    wait_done();
    check("post_reset_start_count", 32'(start_cnt - base), 32'd5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
